// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, FSM state encoding and the hex-to-segment table.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [0:0] state_t;
  localparam state_t SHOW  = 1'b0;
  localparam state_t BLANK = 1'b1;

  // Active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed hex driver with per-slot blanking and frame-synchronous value commit.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank a zero high digit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic [6:0] o_digitalTube,
  output logic       o_sel,
  output logic       o_pending
);

  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW_LAST = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [7:0]       active_q, active_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_q, seg_d;

  logic       slot_end;
  logic       commit;
  logic [3:0] nibble;
  logic [6:0] dec_seg;

  assign nibble = sel_q ? active_q[7:4] : active_q[3:0];

  seg7_hex_decode u_hex_decode (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    slot_end = (state_q == BLANK) && (cnt_q == CNT_LAST);
    // A new frame starts when the high-digit slot ends.
    commit   = slot_end && sel_q;

    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

    state_d = state_q;
    if (state_q == SHOW && cnt_q == CNT_SHOW_LAST) begin
      state_d = BLANK;
    end else if (slot_end) begin
      state_d = SHOW;
    end

    sel_d = slot_end ? ~sel_q : sel_q;

    shadow_d = i_valid ? i_data : shadow_q;
    // shadow_d already carries a same-cycle load, giving the commit-cycle bypass.
    active_d = commit ? shadow_d : active_q;

    pending_d = pending_q;
    if (commit) begin
      pending_d = 1'b0;
    end else if (i_valid) begin
      pending_d = 1'b1;
    end

    seg_d = (state_q == SHOW) ? dec_seg : SEG_BLANK;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (sel_q && active_q[7:4] == 4'h0) begin
      seg_d = SEG_BLANK;
    end
`else
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      state_q   <= SHOW;
      sel_q     <= 1'b0;
      shadow_q  <= 8'h00;
      active_q  <= 8'h00;
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
    end
  end

  assign o_digitalTube = seg_q;
  assign o_sel         = sel_q;
  assign o_pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SCAN_DIV=10, BLANK_CYCLES=2).
module tb_seg7_scan_driver;

  localparam int DIV      = 10;
  localparam int SHOW_CYC = 8;
  localparam int FRAME    = 2 * DIV;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'h7F;
`else
  localparam logic [6:0] HI_ZERO = 7'h40;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic [7:0] i_data;
  logic [6:0] o_digitalTube;
  logic       o_sel;
  logic       o_pending;

  seg7_scan_driver #(
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .o_digitalTube (o_digitalTube),
    .o_sel         (o_sel),
    .o_pending     (o_pending)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    logic [6:0] lo;
    logic [6:0] hi;
  } vec_t;

  vec_t       vecs[16];
  logic [6:0] seg_tab[16];

  int tests = 0;
  int fails = 0;

  // Reference model: positions counted in clock edges since reset release.
  int         n;
  int         last_load_edge;
  logic [7:0] latest;
  logic [7:0] frame_val [int];
  logic       prev_sel;

  function automatic logic [6:0] exp_seg(input int edge_n);
    int p, c, digit;
    logic [7:0] v;
    logic [3:0] nib;
    if (edge_n == 0) return 7'h7F;
    p     = edge_n - 1;
    c     = p % DIV;
    digit = (p / DIV) % 2;
    v     = frame_val[p / FRAME];
    nib   = (digit == 1) ? v[7:4] : v[3:0];
    if (c >= SHOW_CYC) return 7'h7F;
    if (digit == 1 && v[7:4] == 4'h0) return HI_ZERO;
    return seg_tab[nib];
  endfunction

  function automatic logic exp_sel(input int edge_n);
    return ((edge_n / DIV) % 2) == 1;
  endfunction

  function automatic logic exp_pending(input int edge_n);
    return last_load_edge > FRAME * (edge_n / FRAME);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n              = 0;
    last_load_edge = -1;
    latest         = 8'h00;
    frame_val.delete();
    frame_val[0]   = 8'h00;
    prev_sel       = 1'b0;
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    i_valid = v;
    i_data  = d;
    @(posedge i_clk);
    n++;
    if (v) begin
      latest         = d;
      last_load_edge = n;
    end
    if (n % FRAME == 0) frame_val[n / FRAME] = latest;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("seg_model", {25'd0, o_digitalTube}, {25'd0, exp_seg(n)});
    check("sel_model", {31'd0, o_sel}, {31'd0, exp_sel(n)});
    check("pending_model", {31'd0, o_pending}, {31'd0, exp_pending(n)});
    if (o_sel !== prev_sel) check("sel_change_blank", {25'd0, o_digitalTube}, 32'h7F);
    prev_sel = o_sel;
  endtask

  task automatic advance_to(input int pos);
    while (n % FRAME != pos) step(1'b0, 8'h00);
  endtask

  // Show the next frame boundary (no-op when already there) and check both digits.
  task automatic show_frame(input string name, input logic [6:0] lo, input logic [6:0] hi);
    advance_to(0);
    advance_to(5);
    check({name, "_lo"}, {25'd0, o_digitalTube}, {25'd0, lo});
    advance_to(15);
    check({name, "_hi"}, {25'd0, o_digitalTube}, {25'd0, hi});
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0]  = '{8'h10, 7'h40, 7'h79};
    vecs[1]  = '{8'h21, 7'h79, 7'h24};
    vecs[2]  = '{8'h32, 7'h24, 7'h30};
    vecs[3]  = '{8'h43, 7'h30, 7'h19};
    vecs[4]  = '{8'h54, 7'h19, 7'h12};
    vecs[5]  = '{8'h65, 7'h12, 7'h02};
    vecs[6]  = '{8'h76, 7'h02, 7'h78};
    vecs[7]  = '{8'h87, 7'h78, 7'h00};
    vecs[8]  = '{8'h98, 7'h00, 7'h10};
    vecs[9]  = '{8'hA9, 7'h10, 7'h08};
    vecs[10] = '{8'hBA, 7'h08, 7'h03};
    vecs[11] = '{8'hCB, 7'h03, 7'h46};
    vecs[12] = '{8'hDC, 7'h46, 7'h21};
    vecs[13] = '{8'hED, 7'h21, 7'h06};
    vecs[14] = '{8'hFE, 7'h06, 7'h0E};
    vecs[15] = '{8'h1F, 7'h0E, 7'h79};

    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    model_reset();
    #1 i_rst_n = 1'b0;
    #12;
    check("reset_seg", {25'd0, o_digitalTube}, 32'h7F);
    check("reset_sel", {31'd0, o_sel}, 32'h0);
    check("reset_pending", {31'd0, o_pending}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // First frame after reset: low "0" for 8 cycles, blank 2, then high digit.
    for (int i = 1; i <= FRAME; i++) begin
      logic [6:0] es;
      logic       esl;
      step(1'b0, 8'h00);
      if (i <= 8) es = 7'h40;
      else if (i <= 10) es = 7'h7F;
      else if (i <= 18) es = HI_ZERO;
      else es = 7'h7F;
      esl = (i >= 10 && i < 20);
      check("boot_seg", {25'd0, o_digitalTube}, {25'd0, es});
      check("boot_sel", {31'd0, o_sel}, {31'd0, esl});
    end

    // Mid-frame load: pending next cycle, current frame unchanged.
    advance_to(3);
    step(1'b1, 8'hA5);
    check("a5_pending", {31'd0, o_pending}, 32'h1);
    check("a5_old_lo", {25'd0, o_digitalTube}, 32'h40);
    advance_to(15);
    check("a5_old_hi", {25'd0, o_digitalTube}, {25'd0, HI_ZERO});
    show_frame("a5", 7'h12, 7'h08);
    check("a5_pending_clr", {31'd0, o_pending}, 32'h0);

    // Last write wins.
    advance_to(2);
    step(1'b1, 8'h12);
    step(1'b0, 8'h00);
    step(1'b1, 8'h8F);
    show_frame("last_wins", 7'h0E, 7'h00);

    // Load exactly on the commit edge bypasses into this frame.
    advance_to(19);
    step(1'b1, 8'h3C);
    check("bypass_pending", {31'd0, o_pending}, 32'h0);
    show_frame("bypass", 7'h46, 7'h30);

    // Decode sweep over every low nibble.
    for (int k = 0; k < 16; k++) begin
      advance_to(3);
      step(1'b1, vecs[k].data);
      show_frame("sweep", vecs[k].lo, vecs[k].hi);
    end

    // Random loads against the model.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 7) == 0), 8'($urandom));
    end

    // Asynchronous reset in the middle of the high-digit show window.
    advance_to(3);
    step(1'b1, 8'h77);
    advance_to(14);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_seg", {25'd0, o_digitalTube}, 32'h7F);
    check("async_rst_sel", {31'd0, o_sel}, 32'h0);
    check("async_rst_pending", {31'd0, o_pending}, 32'h0);
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    step(1'b0, 8'h00);
    check("post_rst_seg", {25'd0, o_digitalTube}, 32'h40);
    check("post_rst_sel", {31'd0, o_sel}, 32'h0);
    for (int k = 0; k < 2 * FRAME; k++) step(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
